// File: rtl/trace_capture.sv
// Instruction trace ring buffer with a run/halt/timeout controller.
// Captures retired-instruction samples until the halt word is seen or the cycle budget expires.
module trace_capture #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned MAX_CYCLES = 1024,
  parameter logic [31:0] HALT_INST  = 32'h0000006F,
  localparam int unsigned AW        = $clog2(DEPTH)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            en,
  input  logic [XLEN-1:0] pc,
  input  logic [31:0]     inst,
  input  logic [4:0]      rd,
  input  logic [XLEN-1:0] alu_out,
  input  logic [AW-1:0]   rd_idx,
  output logic [XLEN-1:0] rd_pc,
  output logic [31:0]     rd_inst,
  output logic [4:0]      rd_rd,
  output logic [XLEN-1:0] rd_alu,
  output logic [AW:0]     count,
  output logic            wrapped,
  output logic [15:0]     cycles,
  output logic [1:0]      state,
  output logic            done
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_RUN     = 2'b01,
    S_HALTED  = 2'b10,
    S_TIMEOUT = 2'b11
  } state_e;

  localparam logic [AW:0] FULL       = (AW+1)'(DEPTH);
  localparam logic [15:0] LAST_CYCLE = 16'(MAX_CYCLES - 1);

  state_e          state_q, state_d;
  logic [AW-1:0]   wp_q, wp_d;
  logic [AW:0]     count_q, count_d;
  logic            wrapped_q, wrapped_d;
  logic [15:0]     cycles_q, cycles_d;

  logic [XLEN-1:0] mem_pc_q   [DEPTH];
  logic [31:0]     mem_inst_q [DEPTH];
  logic [4:0]      mem_rd_q   [DEPTH];
  logic [XLEN-1:0] mem_alu_q  [DEPTH];

  logic            capture;
  logic            halt_hit;
  logic [AW-1:0]   oldest;
  logic [AW-1:0]   rd_addr;
  logic            rd_valid;

  always_comb begin
    capture   = en && (state_q == S_IDLE || state_q == S_RUN);
    halt_hit  = capture && (inst == HALT_INST);
    state_d   = state_q;
    wp_d      = wp_q;
    count_d   = count_q;
    wrapped_d = wrapped_q;
    cycles_d  = cycles_q;

    if (capture) begin
      wp_d = wp_q + AW'(1);
      if (count_q == FULL) wrapped_d = 1'b1;
      else                 count_d   = count_q + (AW+1)'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (en) begin
          cycles_d = 16'd1;
          state_d  = halt_hit ? S_HALTED : S_RUN;
        end
      end
      S_RUN: begin
        cycles_d = cycles_q + 16'd1;
        // A halt sample outranks the budget expiring on the same cycle.
        if (halt_hit)                     state_d = S_HALTED;
        else if (cycles_q == LAST_CYCLE)  state_d = S_TIMEOUT;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      wp_q      <= '0;
      count_q   <= '0;
      wrapped_q <= 1'b0;
      cycles_q  <= '0;
    end else begin
      state_q   <= state_d;
      wp_q      <= wp_d;
      count_q   <= count_d;
      wrapped_q <= wrapped_d;
      cycles_q  <= cycles_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (capture && !RST) begin
      mem_pc_q[wp_q]   <= pc;
      mem_inst_q[wp_q] <= inst;
      mem_rd_q[wp_q]   <= rd;
      mem_alu_q[wp_q]  <= alu_out;
    end
  end

  // Once full, the write pointer also marks the oldest entry.
  always_comb begin
    oldest   = (count_q == FULL) ? wp_q : '0;
    rd_addr  = oldest + rd_idx;
    rd_valid = {1'b0, rd_idx} < count_q;
    rd_pc    = rd_valid ? mem_pc_q[rd_addr]   : '0;
    rd_inst  = rd_valid ? mem_inst_q[rd_addr] : '0;
    rd_rd    = rd_valid ? mem_rd_q[rd_addr]   : '0;
    rd_alu   = rd_valid ? mem_alu_q[rd_addr]  : '0;
  end

  assign count   = count_q;
  assign wrapped = wrapped_q;
  assign cycles  = cycles_q;
  assign state   = state_q;
  assign done    = (state_q == S_HALTED) || (state_q == S_TIMEOUT);

endmodule

// File: tb/tb_trace_capture.sv
// Randomized bench for trace_capture: two instances (long budget / short budget)
// checked against a queue-based reference model every cycle.
`timescale 1ns/1ps
module tb_trace_capture;

  localparam int unsigned DA = 16, DB = 8, MA = 1024, MB = 8;
  localparam logic [31:0] HALT = 32'h0000006F;
  localparam logic [31:0] NOP  = 32'h00000013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  rd;
    logic [31:0] alu;
  } entry_t;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RST, en;
  logic [31:0] pc, inst, alu_out;
  logic [4:0]  rd;
  logic [3:0]  rd_idx_a;
  logic [2:0]  rd_idx_b;

  logic [31:0] rd_pc_a, rd_inst_a, rd_alu_a, rd_pc_b, rd_inst_b, rd_alu_b;
  logic [4:0]  rd_rd_a, rd_rd_b;
  logic [4:0]  count_a;
  logic [3:0]  count_b;
  logic        wrapped_a, wrapped_b, done_a, done_b;
  logic [15:0] cycles_a, cycles_b;
  logic [1:0]  state_a, state_b;

  trace_capture #(.XLEN(32), .DEPTH(DA), .MAX_CYCLES(MA), .HALT_INST(HALT)) u_a (
    .CLK(CLK), .RST(RST), .en(en), .pc(pc), .inst(inst), .rd(rd), .alu_out(alu_out),
    .rd_idx(rd_idx_a), .rd_pc(rd_pc_a), .rd_inst(rd_inst_a), .rd_rd(rd_rd_a),
    .rd_alu(rd_alu_a), .count(count_a), .wrapped(wrapped_a), .cycles(cycles_a),
    .state(state_a), .done(done_a));

  trace_capture #(.XLEN(32), .DEPTH(DB), .MAX_CYCLES(MB), .HALT_INST(HALT)) u_b (
    .CLK(CLK), .RST(RST), .en(en), .pc(pc), .inst(inst), .rd(rd), .alu_out(alu_out),
    .rd_idx(rd_idx_b), .rd_pc(rd_pc_b), .rd_inst(rd_inst_b), .rd_rd(rd_rd_b),
    .rd_alu(rd_alu_b), .count(count_b), .wrapped(wrapped_b), .cycles(cycles_b),
    .state(state_b), .done(done_b));

  // Reference model: history queue (oldest first), status 0 idle/1 run/2 halted/3 timeout.
  entry_t      hist[2][$];
  int unsigned st[2], cyc[2], wr[2];
  int unsigned depth[2] = '{DA, DB};
  int unsigned maxc[2]  = '{MA, MB};

  int unsigned n_cmp = 0, n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input int i, input entry_t s);
    hist[i].push_back(s);
    if (hist[i].size() > depth[i]) begin
      void'(hist[i].pop_front());
      wr[i] = 1;
    end
  endtask

  task automatic model_step(input int i, input bit r, input bit e, input entry_t s);
    bit halt;
    halt = (s.inst == HALT);
    if (r) begin
      st[i] = 0; cyc[i] = 0; wr[i] = 0;
      hist[i].delete();
    end else if (st[i] == 0) begin
      if (e) begin
        push(i, s);
        cyc[i] = 1;
        st[i]  = halt ? 2 : 1;
      end
    end else if (st[i] == 1) begin
      if (e) push(i, s);
      if (e && halt)                 st[i] = 2;
      else if (cyc[i] == maxc[i] - 1) st[i] = 3;
      cyc[i]++;
    end
  endtask

  function automatic entry_t exp_at(input int i, input int unsigned idx);
    if (idx < hist[i].size()) return hist[i][idx];
    return '0;
  endfunction

  task automatic check_all();
    entry_t ea, eb;
    check("a.state",   64'(state_a),   64'(st[0]));
    check("a.done",    64'(done_a),    64'(st[0] >= 2));
    check("a.count",   64'(count_a),   64'(hist[0].size()));
    check("a.wrapped", 64'(wrapped_a), 64'(wr[0]));
    check("a.cycles",  64'(cycles_a),  64'(cyc[0]));
    check("b.state",   64'(state_b),   64'(st[1]));
    check("b.done",    64'(done_b),    64'(st[1] >= 2));
    check("b.count",   64'(count_b),   64'(hist[1].size()));
    check("b.wrapped", 64'(wrapped_b), 64'(wr[1]));
    check("b.cycles",  64'(cycles_b),  64'(cyc[1]));
    for (int k = 0; k < 2; k++) begin
      rd_idx_a = 4'($urandom_range(DA - 1));
      rd_idx_b = 3'($urandom_range(DB - 1));
      #1;
      ea = exp_at(0, rd_idx_a);
      eb = exp_at(1, rd_idx_b);
      check("a.rd_pc",   64'(rd_pc_a),   64'(ea.pc));
      check("a.rd_inst", 64'(rd_inst_a), 64'(ea.inst));
      check("a.rd_rd",   64'(rd_rd_a),   64'(ea.rd));
      check("a.rd_alu",  64'(rd_alu_a),  64'(ea.alu));
      check("b.rd_pc",   64'(rd_pc_b),   64'(eb.pc));
      check("b.rd_inst", 64'(rd_inst_b), 64'(eb.inst));
      check("b.rd_rd",   64'(rd_rd_b),   64'(eb.rd));
      check("b.rd_alu",  64'(rd_alu_b),  64'(eb.alu));
    end
  endtask

  task automatic cycle(input bit r, input bit e, input logic [31:0] p, input logic [31:0] in);
    entry_t s;
    RST = r; en = e; pc = p; inst = in;
    rd = 5'($urandom); alu_out = $urandom;
    s = '{pc: p, inst: in, rd: rd, alu: alu_out};
    @(posedge CLK);
    model_step(0, r, e, s);
    model_step(1, r, e, s);
    #1;
    check_all();
  endtask

  task automatic read_a(input int unsigned idx);
    rd_idx_a = 4'(idx);
    #1;
  endtask

  task automatic read_b(input int unsigned idx);
    rd_idx_b = 3'(idx);
    #1;
  endtask

  initial begin
    RST = 1'b1; en = 1'b0; pc = '0; inst = '0; rd = '0; alu_out = '0;
    rd_idx_a = '0; rd_idx_b = '0;
    foreach (st[i]) begin st[i] = 0; cyc[i] = 0; wr[i] = 0; end

    cycle(1, 0, 0, NOP);
    cycle(1, 1, 32'h100, NOP);
    check("reset.state", 64'(state_a), 64'd0);
    check("reset.count", 64'(count_a), 64'd0);

    // three plain samples
    cycle(0, 1, 0, NOP); cycle(0, 1, 4, NOP); cycle(0, 1, 8, NOP);
    check("three.count", 64'(count_a), 64'd3);
    check("three.wrapped", 64'(wrapped_a), 64'd0);
    read_a(0); check("three.idx0", 64'(rd_pc_a), 64'd0);
    read_a(2); check("three.idx2", 64'(rd_pc_a), 64'd8);
    read_a(3); check("three.idx3", 64'(rd_pc_a), 64'd0);

    // wrap past depth 16
    cycle(1, 0, 0, NOP);
    for (int k = 0; k < 20; k++) cycle(0, 1, 32'(4 * k), NOP);
    check("wrap.count", 64'(count_a), 64'd16);
    check("wrap.wrapped", 64'(wrapped_a), 64'd1);
    read_a(0);  check("wrap.idx0", 64'(rd_pc_a), 64'd16);
    read_a(15); check("wrap.idx15", 64'(rd_pc_a), 64'd76);

    // halt word ends the run and freezes everything
    cycle(1, 0, 0, NOP);
    cycle(0, 1, 0, NOP); cycle(0, 1, 4, NOP); cycle(0, 1, 8, HALT);
    check("halt.state", 64'(state_a), 64'd2);
    check("halt.done", 64'(done_a), 64'd1);
    check("halt.count", 64'(count_a), 64'd3);
    for (int k = 0; k < 3; k++) cycle(0, 1, 32'h200, NOP);
    check("halt.frozen_count", 64'(count_a), 64'd3);
    check("halt.frozen_cycles", 64'(cycles_a), 64'd3);

    // short budget instance: timeout, then halt on the last budgeted sample
    cycle(1, 0, 0, NOP);
    for (int k = 0; k < 8; k++) cycle(0, 1, 32'(4 * k), NOP);
    check("tmo.state", 64'(state_b), 64'd3);
    check("tmo.cycles", 64'(cycles_b), 64'd8);
    check("tmo.count", 64'(count_b), 64'd8);
    cycle(1, 0, 0, NOP);
    for (int k = 0; k < 7; k++) cycle(0, 1, 32'(4 * k), NOP);
    cycle(0, 1, 28, HALT);
    check("tmo_halt.state", 64'(state_b), 64'd2);
    check("tmo_halt.cycles", 64'(cycles_b), 64'd8);
    read_b(7); check("tmo_halt.inst", 64'(rd_inst_b), 64'(HALT));

    // reset mid-run
    cycle(1, 0, 0, NOP);
    for (int k = 0; k < 5; k++) cycle(0, 1, 32'(4 * k + 4), NOP);
    cycle(1, 1, 32'h300, NOP);
    check("mrst.state", 64'(state_a), 64'd0);
    check("mrst.count", 64'(count_a), 64'd0);
    check("mrst.cycles", 64'(cycles_a), 64'd0);
    read_a(0); check("mrst.idx0", 64'(rd_pc_a), 64'd0);
    read_a(4); check("mrst.idx4", 64'(rd_pc_a), 64'd0);

    // halt as very first sample
    cycle(0, 1, 32'h40, HALT);
    check("first_halt.state", 64'(state_a), 64'd2);
    check("first_halt.count", 64'(count_a), 64'd1);
    read_a(0); check("first_halt.inst", 64'(rd_inst_a), 64'(HALT));

    // random runs
    for (int run = 0; run < 8; run++) begin
      int unsigned n;
      cycle(1, 0, 0, NOP);
      n = $urandom_range(60, 10);
      for (int k = 0; k < int'(n); k++) begin
        bit r, e;
        logic [31:0] in;
        r  = ($urandom_range(60) == 0);
        e  = ($urandom_range(3) != 0);
        in = ($urandom_range(40) == 0) ? HALT : $urandom;
        cycle(r, e, $urandom, in);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
